// File: rtl/alu_sequencer.sv
// Multi-cycle ALU command sequencer: register file, operand staging toward an
// external combinational ALU, and a valid/ready response with an error flag.
module alu_sequencer #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [2:0]       cmd_rd,
    input  logic [2:0]       cmd_rs,
    input  logic [2:0]       cmd_rt,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err
);

    typedef enum logic [1:0] {IDLE, OPER, EXEC, RESP} state_t;

    state_t           state;
    logic [WIDTH-1:0] regs [NREG];
    logic [2:0]       op_q, rd_q, rs_q, rt_q;

    function automatic logic op_legal(input logic [2:0] op);
        return !(op == 3'b011 || op == 3'b100 || op == 3'b101);
    endfunction

    function automatic logic [WIDTH-1:0] rd_reg(input logic [2:0] a);
        return (a == 3'd0) ? '0 : regs[a];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (wr_en && wr_addr != 3'd0) regs[wr_addr] <= wr_data;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        rd_q      <= cmd_rd;
                        rs_q      <= cmd_rs;
                        rt_q      <= cmd_rt;
                        cmd_ready <= 1'b0;
                        state     <= OPER;
                    end
                end
                OPER: begin
                    alu_op <= op_q;
                    alu_a  <= rd_reg(rs_q);
                    alu_b  <= rd_reg(rt_q);
                    state  <= EXEC;
                end
                EXEC: begin
                    if (op_legal(op_q)) begin
                        rsp_data <= alu_result;
                        rsp_zero <= alu_zero;
                        rsp_err  <= 1'b0;
                        // Placed after the direct load so it wins a same-address collision.
                        if (rd_q != 3'd0) regs[rd_q] <= alu_result;
                    end else begin
                        rsp_data <= '0;
                        rsp_zero <= 1'b0;
                        rsp_err  <= 1'b1;
                    end
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioral 16-bit ALU attached.
module tb_alu_sequencer;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] d;
        logic         z;
        logic         e;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid, cmd_ready;
    logic [2:0]   cmd_op, cmd_rd, cmd_rs, cmd_rt;
    logic         wr_en;
    logic [2:0]   wr_addr;
    logic [W-1:0] wr_data;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic         alu_zero;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_zero, rsp_err;

    int           checks = 0;
    int           failures = 0;
    exp_t         sbq [$];
    exp_t         mon_e;
    logic [W-1:0] m [8];
    logic [W-1:0] last_d;
    logic         last_z, last_e;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            default: return 16'hDEAD;
        endcase
    endfunction

    function automatic logic legal_f(input logic [2:0] op);
        return op != 3'b011 && op != 3'b100 && op != 3'b101;
    endfunction

    assign alu_result = alu_f(alu_op, alu_a, alu_b);
    assign alu_zero   = (alu_result == '0);

    alu_sequencer #(.WIDTH(W), .NREG(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake happens at the next rising edge; sample mid-cycle.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("rsp_data", 32'(rsp_data), 32'(mon_e.d));
                chk("rsp_zero", 32'(rsp_zero), 32'(mon_e.z));
                chk("rsp_err", 32'(rsp_err), 32'(mon_e.e));
                last_d = rsp_data;
                last_z = rsp_zero;
                last_e = rsp_err;
            end
        end
    end

    task automatic load(input logic [2:0] a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
        if (a != 3'd0) m[a] = d;
    endtask

    task automatic issue(input logic [2:0] op, rd, rs, rt, input bit exec_wr, input bit exec_rst);
        logic [W-1:0] a, b, r;
        exp_t e;
        int lat;
        a = (rs == 3'd0) ? '0 : m[rs];
        b = (rt == 3'd0) ? '0 : m[rt];
        r = alu_f(op, a, b);
        if (!exec_rst) begin
            if (legal_f(op)) begin
                e.d = r; e.z = (r == '0); e.e = 1'b0;
                if (rd != 3'd0) m[rd] = r;
            end else begin
                e.d = '0; e.z = 1'b0; e.e = 1'b1;
            end
            sbq.push_back(e);
        end
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt;
        tick();
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            if (lat == 2 && exec_wr) begin
                wr_en = 1'b1; wr_addr = rd; wr_data = 16'hBEEF;
            end
            if (lat == 2 && exec_rst) reset = 1'b1;
            tick();
            lat++;
            wr_en = 1'b0;
            if (exec_rst && lat == 3) begin
                reset = 1'b0;
                tick();
                for (int i = 0; i < 8; i++) m[i] = '0;
                chk("rst_exec_valid", 32'(rsp_valid), 32'd0);
                chk("rst_exec_ready", 32'(cmd_ready), 32'd1);
                chk("rst_exec_alu_a", 32'(alu_a), 32'd0);
                return;
            end
        end
        chk("latency", lat, 3);
    endtask

    task automatic drain();
        int n = 0;
        while (rsp_valid && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic run(input logic [2:0] op, rd, rs, rt);
        issue(op, rd, rs, rt, 1'b0, 1'b0);
        drain();
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs = '0; cmd_rt = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) m[i] = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_flags", {30'd0, rsp_zero, rsp_err}, 32'd0);
        chk("rst_alu_regs", {13'd0, alu_op, alu_a}, 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);

        load(3'd1, 16'h0007);
        load(3'd2, 16'h0001);
        run(3'b010, 3'd3, 3'd1, 3'd2);
        chk("add_const", {15'd0, last_d, last_z}, {15'd0, 16'h0008, 1'b0});
        run(3'b001, 3'd4, 3'd3, 3'd0);
        chk("or_const", 32'(last_d), 32'h8);

        run(3'b110, 3'd5, 3'd1, 3'd1);
        chk("sub_zero", {15'd0, last_d, last_z}, {15'd0, 16'h0000, 1'b1});
        load(3'd1, 16'hFFFE);
        load(3'd2, 16'hFFFF);
        run(3'b111, 3'd6, 3'd1, 3'd2);
        chk("slt_signed", 32'(last_d), 32'h1);

        run(3'b011, 3'd3, 3'd1, 3'd2);
        chk("illegal", {15'd0, last_d, last_e}, {15'd0, 16'h0000, 1'b1});
        run(3'b001, 3'd6, 3'd3, 3'd0);
        chk("r3_kept", 32'(last_d), 32'h8);

        rsp_ready = 1'b0;
        issue(3'b001, 3'd0, 3'd3, 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cmd_valid = 1'b1; cmd_op = 3'b010; cmd_rd = 3'd5; cmd_rs = 3'd3; cmd_rt = 3'd4;
            tick();
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_data", 32'(rsp_data), 32'h8);
            chk("stall_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();
        run(3'b001, 3'd0, 3'd5, 3'd0);
        chk("ignored_cmd", 32'(last_d), 32'h0);

        run(3'b010, 3'd0, 3'd3, 3'd4);
        chk("add_rd0", 32'(last_d), 32'h10);
        run(3'b001, 3'd0, 3'd0, 3'd0);
        chk("r0_zero", 32'(last_d), 32'h0);

        issue(3'b010, 3'd7, 3'd3, 3'd4, 1'b1, 1'b0);
        drain();
        run(3'b001, 3'd0, 3'd7, 3'd0);
        chk("wb_wins", 32'(last_d), 32'h10);

        issue(3'b010, 3'd3, 3'd3, 3'd4, 1'b0, 1'b1);
        for (int i = 1; i < 8; i++) begin
            run(3'b001, 3'd0, 3'(i), 3'd0);
            chk("reg_cleared", 32'(last_d), 32'h0);
        end

        tick(); tick();
        chk("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
